// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and constants for the fetch/prefetch slice.
// The optional FETCH_PERF_CNT_EN build adds performance counters to the top.
package fetch_pkg;

  localparam int          FETCH_XLEN      = 32;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
  localparam logic [31:0] IRQ_VEC_DEFAULT = 32'h0000_0004;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  // Unknown or all-zero fetch data is replaced by a NOP before it reaches decode.
  function automatic logic [31:0] sanitize_instr(input logic [31:0] instr);
    if ($isunknown(instr) || (instr == 32'h0000_0000)) begin
      return NOP_INSTR;
    end else begin
      return instr;
    end
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Instruction-memory request/response and decode handshake bundle.
interface fetch_prefetch_unit_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req;
  logic            imem_gnt;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_pc_next;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_next,
    input  imem_gnt, imem_rvalid, imem_rdata, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_next,
    output imem_gnt, imem_rvalid, imem_rdata, dec_ready
  );

endinterface

// File: rtl/fetch_prefetch_unit_fifo.sv
// Synchronous prefetch queue of fetch entries; flush wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  // Pointer/count next state; a push into a full queue is only taken alongside a pop.
  always_comb begin
    full_o    = (count_q == CW'(DEPTH));
    empty_o   = (count_q == {CW{1'b0}});
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      wr_ptr_d = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Queue state and storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s && !flush_i) begin
        mem_q[wr_ptr_q] <= entry_i;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: prefetches sequentially ahead of decode and handles redirects.
// Define FETCH_PERF_CNT_EN to add the perf_redirects/perf_starve counters.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 4,
  parameter logic [XLEN-1:0] RESET_PC        = {XLEN{1'b0}},
  parameter logic [XLEN-1:0] IRQ_VEC         = IRQ_VEC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic            interrupt,
  input  logic            rti,
  input  logic            rsi,
  input  logic            halt,
  fetch_prefetch_unit_if.master bus,
  output logic [XLEN-1:0] i_reg_q
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_starve
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = ((OW > CW) ? OW : CW) + 1;

  logic [OW-1:0]   outstanding_q, outstanding_d, drop_q, drop_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, deliver_pc_q, deliver_pc_d, i_reg_d;
  logic [XLEN-1:0] target_s;
  logic [SW-1:0]   occupancy_s;
  logic [CW-1:0]   fifo_count_s;
  logic            redirect_s, issue_s, accept_s, rsp_s, push_s, pop_s, dec_valid_s;
  logic            fifo_full_s, fifo_empty_s;
  fetch_entry_t    push_entry_s, head_s;

  // Redirect selection, issue rule, queue handshakes and next state.
  always_comb begin
    redirect_s = interrupt | rti | branch;
    if (interrupt) begin
      target_s = IRQ_VEC;
    end else if (rti) begin
      target_s = i_reg_q;
    end else begin
      target_s = branch_target;
    end
    occupancy_s = SW'(outstanding_q) + SW'(fifo_count_s);
    issue_s     = rst_n & ~halt & ~redirect_s & (occupancy_s < SW'(DEPTH))
                  & (outstanding_q < OW'(MAX_OUTSTANDING));
    accept_s    = issue_s & bus.imem_gnt;
    rsp_s       = bus.imem_rvalid & (outstanding_q != {OW{1'b0}});
    dec_valid_s = rst_n & ~fifo_empty_s & ~redirect_s;
    pop_s       = dec_valid_s & bus.dec_ready;
    push_s      = rsp_s & (drop_q == {OW{1'b0}}) & (~fifo_full_s | pop_s);
    // Responses return in order, so the next one belongs just past the queued entries.
    push_entry_s.pc    = deliver_pc_q + XLEN'({fifo_count_s, 2'b00});
    push_entry_s.instr = sanitize_instr(bus.imem_rdata);

    outstanding_d = outstanding_q + OW'(accept_s) - OW'(rsp_s);
    if (redirect_s) begin
      drop_d       = outstanding_q - OW'(rsp_s);
      fetch_pc_d   = target_s;
      deliver_pc_d = target_s;
    end else begin
      drop_d       = drop_q - OW'(rsp_s & (drop_q != {OW{1'b0}}));
      fetch_pc_d   = accept_s ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
      deliver_pc_d = pop_s ? deliver_pc_q + XLEN'(4) : deliver_pc_q;
    end

    if (interrupt) begin
      i_reg_d = branch ? branch_target : deliver_pc_q;
    end else if (rsi) begin
      i_reg_d = {XLEN{1'b0}};
    end else begin
      i_reg_d = i_reg_q;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding_q <= {OW{1'b0}};
      drop_q        <= {OW{1'b0}};
      fetch_pc_q    <= RESET_PC;
      deliver_pc_q  <= RESET_PC;
      i_reg_q       <= {XLEN{1'b0}};
    end else begin
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fetch_pc_q    <= fetch_pc_d;
      deliver_pc_q  <= deliver_pc_d;
      i_reg_q       <= i_reg_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_s),
    .push_i  (push_s),
    .entry_i (push_entry_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign bus.imem_req    = issue_s;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.dec_valid   = dec_valid_s;
  assign bus.dec_instr   = dec_valid_s ? head_s.instr : NOP_INSTR;
  assign bus.dec_pc      = dec_valid_s ? head_s.pc : {XLEN{1'b0}};
  assign bus.dec_pc_next = dec_valid_s ? head_s.pc + XLEN'(4) : {XLEN{1'b0}};

`ifdef FETCH_PERF_CNT_EN
  // Saturating redirect and decode-starvation counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_redirects <= 32'h0000_0000;
      perf_starve    <= 32'h0000_0000;
    end else begin
      if (redirect_s && (perf_redirects != 32'hFFFF_FFFF)) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
      if (!dec_valid_s && !halt && (perf_starve != 32'hFFFF_FFFF)) begin
        perf_starve <= perf_starve + 32'd1;
      end
    end
  end
`endif

endmodule
